branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch predictor for the 5-stage RV32I pipeline: a direct-mapped branch target buffer with 2-bit saturating direction counters. Fetch queries it combinationally with the current PC to choose the next PC. Execute resolves each branch or jump, trains the table, and receives a mispredict flag plus a corrected redirect PC. This replaces the pipeline's static "always not-taken, flush on every taken control transfer" behaviour.

## Interface
- XLEN, 32, data/address width.
- ENTRIES, 64, table entries; power of 2, ≥2; IDX_W = log2(ENTRIES).
- MODE, 1, 0 = static not-taken (table still trains, prediction forced off); 1 = bimodal BTB prediction.
- COUNTER_INIT, 2'b01, counter value after reset/flush.

- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high.
- pc_f  in  XLEN  fetch-stage PC.
- pred_taken_f  out  1  predicted taken for pc_f.
- pred_target_f  out  XLEN  predicted next PC for pc_f.
- update_valid_e  in  1  execute holds a resolved branch or jump (JAL/JALR/Bxx).
- update_pc_e  in  XLEN  PC of the resolved instruction.
- update_is_jump_e  in  1  unconditional jump (JAL/JALR).
- update_taken_e  in  1  actual direction.
- update_target_e  in  XLEN  actual target.
- pred_taken_e  in  1  prediction carried down the pipeline with the instruction.
- pred_target_e  in  XLEN  predicted next PC carried with the instruction.
- mispredict_e  out  1  prediction was wrong; pipeline must flush D/E.
- redirect_pc_e  out  XLEN  correct next PC when mispredict_e = 1.
- flush_i  in  1  invalidate the whole table (fence.i).
- branch_count  out  32  resolved updates, saturating.
- mispredict_count  out  32  mispredicts, saturating.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2].
- Each entry holds: valid, tag, target, 2-bit counter, is_jump.
- Lookup (combinational):
  - hit = valid & (tag == pc_f tag).
  - pred_taken_f = MODE & hit & (is_jump | counter[1]).
  - pred_target_f = pred_taken_f ? entry target : pc_f + 4.
- Update, on a clock edge when update_valid_e & !rst & !flush_i:
  - Hit, taken: counter saturating +1 (max 2'b11); target ← update_target_e; is_jump ← update_is_jump_e.
  - Hit, not taken: counter saturating −1 (min 2'b00); target unchanged.
  - Miss, taken: allocate (overwrite any existing entry). valid = 1; tag, target and is_jump from the update; counter = 2'b10.
  - Miss, not taken: no allocation; no table change.
- mispredict_e = update_valid_e & ((update_taken_e != pred_taken_e) | (update_taken_e & (update_target_e != pred_target_e))).
- redirect_pc_e = update_taken_e ? update_target_e : update_pc_e + 4. It is valid whenever update_valid_e = 1.
- Performance counters, on a clock edge:
  - branch_count increments on update_valid_e.
  - mispredict_count increments on mispredict_e.
  - Both saturate at 32'hFFFFFFFF.
  - Both are unaffected by flush_i.
- flush_i clears every valid bit and sets every counter to COUNTER_INIT in one cycle. When flush_i and update_valid_e occur together, flush wins and the update is dropped. The mispredict output and the performance counters still respond to that update.
- All PC arithmetic is modulo 2^XLEN; pc + 4 wraps.

## Timing
- Lookup: 0-cycle combinational path from pc_f to pred_taken_f and pred_target_f.
- Mispredict: 0-cycle combinational path from the update inputs to mispredict_e and redirect_pc_e.
- A table write at edge N is visible to lookups from cycle N onward (after the edge). A lookup to the same index in the update cycle returns the old contents.
- Reset (synchronous, any cycle, including mid-update):
  - All valid = 0; counters = COUNTER_INIT; branch_count = mispredict_count = 0.
  - Updates in the rst cycle are ignored.
  - After reset, pred_taken_f = 0 and pred_target_f = pc_f + 4.
- Reset outputs: mispredict_e is combinational and follows its inputs during reset.
- Aliasing: PCs differing only in tag bits evict each other; tag compare prevents false hits.

## Test plan
- Reset, then pc_f = 0x100 → pred_taken_f = 0, pred_target_f = 0x104. Both performance counters = 0.
- Taken branch at 0x100 to 0x80, with pred_taken_e = 0:
  - In the update cycle: mispredict_e = 1, redirect_pc_e = 0x80.
  - Next cycle, pc_f = 0x100 → pred_taken_f = 1, target 0x80.
- Counter saturation and hysteresis: train 0x100 taken ×3 (counter 11), then not-taken ×1 → still predicts taken. A second not-taken → predicts not-taken. Not-taken ×5 holds at 00 with no underflow.
- Aliasing, with ENTRIES = 64:
  - Allocate 0x100 taken, then 0x200 taken (same index, different tag).
  - pc_f = 0x100 → miss, pred_taken_f = 0. pc_f = 0x200 → hit.
- JAL at 0x40 to 0x400: after one update, predicted taken regardless of counter. A not-taken update is never issued for a jump. MODE = 0 → pred_taken_f = 0 always, with the table still trained.
- Simultaneous events:
  - flush_i with an update to 0x100 → 0x100 misses next cycle; branch_count still increments.
  - rst asserted during an update → table empty, counters 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters for the RV32I fetch stage.
// Fetch looks up combinationally; execute trains the table and reports mispredicts.
module branch_predictor #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ENTRIES      = 64,
  parameter int unsigned MODE         = 1,
  parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            update_valid_e,
  input  logic [XLEN-1:0] update_pc_e,
  input  logic            update_is_jump_e,
  input  logic            update_taken_e,
  input  logic [XLEN-1:0] update_target_e,
  input  logic            pred_taken_e,
  input  logic [XLEN-1:0] pred_target_e,
  output logic            mispredict_e,
  output logic [XLEN-1:0] redirect_pc_e,
  input  logic            flush_i,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned     IDX_W   = $clog2(ENTRIES);
  localparam int unsigned     TAG_W   = XLEN - IDX_W - 2;
  localparam bit              PRED_EN = (MODE != 0);
  localparam logic [XLEN-1:0] PC_INC  = XLEN'(4);

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic               jump_q   [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, table_we;

  // Byte-offset bits never select anything in a 4-byte-aligned instruction stream.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, pc_f[1:0], update_pc_e[1:0]};

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[XLEN-1:IDX_W+2];
  assign e_idx = update_pc_e[IDX_W+1:2];
  assign e_tag = update_pc_e[XLEN-1:IDX_W+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Flush and reset both take priority over a concurrent update.
  assign table_we = update_valid_e && !rst && !flush_i;

  always_comb begin
    pred_taken_f  = PRED_EN && f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
    pred_target_f = pred_taken_f ? target_q[f_idx] : pc_f + PC_INC;
  end

  always_comb begin
    mispredict_e  = update_valid_e &&
                    ((update_taken_e != pred_taken_e) ||
                     (update_taken_e && (update_target_e != pred_target_e)));
    redirect_pc_e = update_taken_e ? update_target_e : update_pc_e + PC_INC;
  end

  // NOTE: only valid bits and counters need a reset; tag/target/is_jump are
  // never read while valid is clear, so they stay plain RAM without reset.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= COUNTER_INIT;
    end else if (update_valid_e) begin
      if (e_hit) begin
        if (update_taken_e) begin
          if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
        end else begin
          if (ctr_q[e_idx] != 2'b00) ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
        end
      end else if (update_taken_e) begin
        valid_q[e_idx] <= 1'b1;
        ctr_q[e_idx]   <= 2'b10;
      end
    end
  end

  // A taken update either refreshes a hit entry or allocates over the slot.
  always_ff @(posedge clk) begin
    if (table_we && update_taken_e) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= update_target_e;
      jump_q[e_idx]   <= update_is_jump_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_valid_e && (branch_count != '1))
        branch_count <= branch_count + 32'd1;
      if (mispredict_e && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule
